// File: rtl/fetch_pc_stage.sv
// rtl/fetch_pc_stage.sv - fetch PC sequencer and IF/ID pipeline register
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        eval_branch,
  input  logic        predict_branch,
  input  logic [31:0] target_final,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        pred_taken_d,
  output logic [31:0] pred_target_d,
  output logic        valid_d,
  output logic        misalign_err,
  output logic [31:0] pred_taken_cnt,
  output logic [31:0] redirect_cnt
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pc_plus4_d_q, pc_plus4_d_d;
  logic        pred_taken_d_q, pred_taken_d_d;
  logic [31:0] pred_target_d_q, pred_target_d_d;
  logic        valid_d_q, valid_d_d;
  logic        misalign_err_q, misalign_err_d;

  logic [31:0] pc_plus4_f;
  logic [31:0] target_aligned;
  logic        target_taken;
  logic        id_clear;
  logic        id_load;

  assign pc_plus4_f     = pc_f_q + 32'd4;
  assign target_aligned = {target_final[31:2], 2'b00};
  // A redirect overrides stall_f; a prediction only counts when the PC actually moves.
  assign target_taken   = eval_branch | (predict_branch & ~stall_f);
  assign id_clear       = eval_branch | flush_d;
  assign id_load        = ~id_clear & ~stall_d;

  always_comb begin
    pc_f_d         = pc_f_q;
    misalign_err_d = misalign_err_q;
    if (eval_branch) begin
      pc_f_d = target_aligned;
    end else if (!stall_f) begin
      pc_f_d = predict_branch ? target_aligned : pc_plus4_f;
    end
    if (target_taken && (target_final[1:0] != 2'b00)) begin
      misalign_err_d = 1'b1;
    end
  end

  always_comb begin
    instr_d_d       = instr_d_q;
    pc_d_d          = pc_d_q;
    pc_plus4_d_d    = pc_plus4_d_q;
    pred_taken_d_d  = pred_taken_d_q;
    pred_target_d_d = pred_target_d_q;
    valid_d_d       = valid_d_q;
    if (id_clear) begin
      instr_d_d       = NOP_INSTR;
      pc_d_d          = pc_f_q;
      pc_plus4_d_d    = pc_plus4_f;
      pred_taken_d_d  = 1'b0;
      pred_target_d_d = 32'h0;
      valid_d_d       = 1'b0;
    end else if (id_load) begin
      instr_d_d       = instr_f;
      pc_d_d          = pc_f_q;
      pc_plus4_d_d    = pc_plus4_f;
      pred_taken_d_d  = predict_branch;
      pred_target_d_d = target_final;
      valid_d_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q          <= RESET_PC;
      instr_d_q       <= NOP_INSTR;
      pc_d_q          <= 32'h0;
      pc_plus4_d_q    <= 32'h0;
      pred_taken_d_q  <= 1'b0;
      pred_target_d_q <= 32'h0;
      valid_d_q       <= 1'b0;
      misalign_err_q  <= 1'b0;
    end else begin
      pc_f_q          <= pc_f_d;
      instr_d_q       <= instr_d_d;
      pc_d_q          <= pc_d_d;
      pc_plus4_d_q    <= pc_plus4_d_d;
      pred_taken_d_q  <= pred_taken_d_d;
      pred_target_d_q <= pred_target_d_d;
      valid_d_q       <= valid_d_d;
      misalign_err_q  <= misalign_err_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pred_taken_cnt_q, pred_taken_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    pred_taken_cnt_d = pred_taken_cnt_q;
    redirect_cnt_d   = redirect_cnt_q;
    if (id_load && predict_branch) pred_taken_cnt_d = pred_taken_cnt_q + 32'd1;
    if (eval_branch)               redirect_cnt_d   = redirect_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_taken_cnt_q <= 32'h0;
      redirect_cnt_q   <= 32'h0;
    end else begin
      pred_taken_cnt_q <= pred_taken_cnt_d;
      redirect_cnt_q   <= redirect_cnt_d;
    end
  end

  assign pred_taken_cnt = pred_taken_cnt_q;
  assign redirect_cnt   = redirect_cnt_q;
`else
  assign pred_taken_cnt = 32'h0;
  assign redirect_cnt   = 32'h0;
`endif

  assign pc_f          = pc_f_q;
  assign instr_d       = instr_d_q;
  assign pc_d          = pc_d_q;
  assign pc_plus4_d    = pc_plus4_d_q;
  assign pred_taken_d  = pred_taken_d_q;
  assign pred_target_d = pred_target_d_q;
  assign valid_d       = valid_d_q;
  assign misalign_err  = misalign_err_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// tb/tb_fetch_pc_stage.sv - scoreboard bench for fetch_pc_stage
// Counter expectations follow FETCH_PERF_CNT_EN.
module tb_fetch_pc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f, stall_d, flush_d, eval_branch, predict_branch;
  logic [31:0] target_final, instr_f;
  logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d, pred_target_d;
  logic        pred_taken_d, valid_d, misalign_err;
  logic [31:0] pred_taken_cnt, redirect_cnt;

  typedef struct {
    int          step;
    logic [31:0] pc_f, instr, pc, pc4, tgt, ptc, rdc;
    logic        pt, v, mis;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_pc_stage #(.RESET_PC(32'h100), .NOP_INSTR(32'h13)) dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .eval_branch(eval_branch), .predict_branch(predict_branch),
    .target_final(target_final), .instr_f(instr_f), .pc_f(pc_f), .instr_d(instr_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .pred_taken_d(pred_taken_d),
    .pred_target_d(pred_target_d), .valid_d(valid_d), .misalign_err(misalign_err),
    .pred_taken_cnt(pred_taken_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: a recognisable word tagged with the low PC bits.
  assign instr_f = {16'hC0DE, pc_f[15:0]};

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic step(input int n, input logic rst, input logic sf, input logic sd, input logic fl,
                      input logic ev, input logic pr, input logic [31:0] tgt,
                      input logic [31:0] e_pc_f, input logic [31:0] e_instr, input logic [31:0] e_pc,
                      input logic [31:0] e_pc4, input logic e_pt, input logic [31:0] e_tgt,
                      input logic e_v, input logic e_mis, input int e_ptc, input int e_rdc);
    exp_t e;
    reset = rst; stall_f = sf; stall_d = sd; flush_d = fl;
    eval_branch = ev; predict_branch = pr; target_final = tgt;
    e.step = n; e.pc_f = e_pc_f; e.instr = e_instr; e.pc = e_pc; e.pc4 = e_pc4;
    e.pt = e_pt; e.tgt = e_tgt; e.v = e_v; e.mis = e_mis;
    e.ptc = PERF ? e_ptc : 0;
    e.rdc = PERF ? e_rdc : 0;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_f", e.step, pc_f, e.pc_f);
        chk("instr_d", e.step, instr_d, e.instr);
        chk("pc_d", e.step, pc_d, e.pc);
        chk("pc_plus4_d", e.step, pc_plus4_d, e.pc4);
        chk("pred_taken_d", e.step, {31'h0, pred_taken_d}, {31'h0, e.pt});
        chk("pred_target_d", e.step, pred_target_d, e.tgt);
        chk("valid_d", e.step, {31'h0, valid_d}, {31'h0, e.v});
        chk("misalign_err", e.step, {31'h0, misalign_err}, {31'h0, e.mis});
        chk("pred_taken_cnt", e.step, pred_taken_cnt, e.ptc);
        chk("redirect_cnt", e.step, redirect_cnt, e.rdc);
      end
    end
  end

  initial begin : stimulus
    int wait_cycles;
    reset = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0;
    eval_branch = 0; predict_branch = 0; target_final = 0;
    //   n rst sf sd fl ev pr target        pc_f          instr         pc_d          pc4           pt tgt           v mis ptc rdc
    step( 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h100,      32'h13,       32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 0);
    step( 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h104,      32'hC0DE0100, 32'h100,      32'h104,      0, 32'h0,        1, 0, 0, 0);
    step( 2, 0, 0, 0, 0, 0, 0, 32'h0,        32'h108,      32'hC0DE0104, 32'h104,      32'h108,      0, 32'h0,        1, 0, 0, 0);
    step( 3, 0, 0, 0, 0, 0, 1, 32'h200,      32'h200,      32'hC0DE0108, 32'h108,      32'h10C,      1, 32'h200,      1, 0, 1, 0);
    step( 4, 0, 0, 0, 0, 0, 0, 32'h0,        32'h204,      32'hC0DE0200, 32'h200,      32'h204,      0, 32'h0,        1, 0, 1, 0);
    step( 5, 0, 1, 1, 0, 1, 0, 32'h40,       32'h40,       32'h13,       32'h204,      32'h208,      0, 32'h0,        0, 0, 1, 1);
    step( 6, 0, 0, 0, 0, 0, 0, 32'h0,        32'h44,       32'hC0DE0040, 32'h40,       32'h44,       0, 32'h0,        1, 0, 1, 1);
    step( 7, 0, 1, 1, 0, 0, 1, 32'h500,      32'h44,       32'hC0DE0040, 32'h40,       32'h44,       0, 32'h0,        1, 0, 1, 1);
    step( 8, 0, 1, 1, 0, 0, 1, 32'h500,      32'h44,       32'hC0DE0040, 32'h40,       32'h44,       0, 32'h0,        1, 0, 1, 1);
    step( 9, 0, 1, 1, 0, 0, 1, 32'h500,      32'h44,       32'hC0DE0040, 32'h40,       32'h44,       0, 32'h0,        1, 0, 1, 1);
    step(10, 0, 1, 1, 1, 0, 0, 32'h0,        32'h44,       32'h13,       32'h44,       32'h48,       0, 32'h0,        0, 0, 1, 1);
    step(11, 0, 0, 0, 0, 0, 0, 32'h0,        32'h48,       32'hC0DE0044, 32'h44,       32'h48,       0, 32'h0,        1, 0, 1, 1);
    step(12, 0, 0, 0, 0, 0, 1, 32'h302,      32'h300,      32'hC0DE0048, 32'h48,       32'h4C,       1, 32'h302,      1, 1, 2, 1);
    step(13, 0, 0, 0, 0, 0, 0, 32'h0,        32'h304,      32'hC0DE0300, 32'h300,      32'h304,      0, 32'h0,        1, 1, 2, 1);
    step(14, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hC0DE0304, 32'h304,      32'h308,      1, 32'hFFFFFFFC, 1, 1, 3, 1);
    step(15, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hC0DEFFFC, 32'hFFFFFFFC, 32'h0,        0, 32'h0,        1, 1, 3, 1);
    step(16, 0, 0, 0, 0, 0, 1, 32'h80,       32'h80,       32'hC0DE0000, 32'h0,        32'h4,        1, 32'h80,       1, 1, 4, 1);
    step(17, 0, 0, 0, 0, 0, 1, 32'h90,       32'h90,       32'hC0DE0080, 32'h80,       32'h84,       1, 32'h90,       1, 1, 5, 1);
    step(18, 0, 0, 0, 0, 1, 0, 32'h20,       32'h20,       32'h13,       32'h90,       32'h94,       0, 32'h0,        0, 1, 5, 2);
    // Mid-cycle reset must take effect before any clock edge.
    reset = 1'b1;
    #1;
    chk("async_reset_pc_f", 19, pc_f, 32'h100);
    chk("async_reset_misalign", 19, {31'h0, misalign_err}, 32'h0);
    step(19, 1, 0, 0, 0, 0, 0, 32'h0,        32'h100,      32'h13,       32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 0);
    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
